// File: rtl/deser_arb_pkg.sv
// Shared types and constants for the deserializer arbiter.
// Frame length is fixed to the deserializer word width.
package deser_arb_pkg;

    localparam int FRAME_LEN = 16;
    localparam int WORD_W    = 16;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Increment modulo n; safe for non-power-of-2 requester counts.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod N.
// Zero latency; no backpressure, the caller owns the pointer register.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        int   cand;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/deser_arbiter.sv
// Shares one 16-bit deserializer among N_SRC serial lanes, one frame per grant; bits forwarded with 0 latency.
// Word tagged with source ID 2 cycles after the 16th bit; frames stretch over data_val_i gaps, no buffering.
module deser_arbiter
    import deser_arb_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [N_SRC-1:0]  req_i,
    input  logic [N_SRC-1:0]  data_i,
    input  logic [N_SRC-1:0]  data_val_i,
    output logic [N_SRC-1:0]  gnt_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    input  logic [WORD_W-1:0] deser_data_i,
    input  logic              deser_data_val_i,
    output logic [WORD_W-1:0] word_o,
    output logic [ID_W-1:0]   word_id_o,
    output logic              word_val_o,
    output logic              busy_o
);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  g_idx;
    logic [N_SRC-1:0] arb_gnt;
    logic [ID_W-1:0]  arb_idx;

    rr_arbiter #(
        .N (N_SRC)
    ) u_rr_arbiter (
        .req     (req_i),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Only the granted lane reaches the deserializer, and only while a frame is open.
    always_comb begin
        ser_data_o     = 1'b0;
        ser_data_val_o = 1'b0;
        if (state == XFER) begin
            ser_data_o     = data_i[g_idx];
            ser_data_val_o = data_val_i[g_idx];
        end
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            ptr        <= '0;
            g_idx      <= '0;
            gnt_o      <= '0;
            word_o     <= '0;
            word_id_o  <= '0;
            word_val_o <= 1'b0;
        end else begin
            word_val_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt_o <= arb_gnt;
                        g_idx <= arb_idx;
                        ptr   <= ID_W'(wrap_inc(int'(arb_idx), N_SRC));
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (ser_data_val_o) begin
                        if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                            bit_cnt <= '0;
                            gnt_o   <= '0;
                            state   <= DRAIN;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (deser_data_val_i) begin
                        word_o     <= deser_data_i;
                        word_id_o  <= g_idx;
                        word_val_o <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
